// File: rtl/debouncer_multi.sv
// N-channel button conditioner: two-flop synchroniser, per-channel debounce window,
// clean pressed level plus single-cycle press, release and long-press/auto-repeat pulses.
module debouncer_multi #(
    parameter int CHANNELS      = 4,
    parameter int CNT_W         = 16,
    parameter int DB_CYCLES     = 50000,
    parameter int ACTIVE_LOW    = 1,
    parameter int HOLD_W        = 26,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic                clk50M,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] pressed_state,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse
);

    localparam logic [CNT_W-1:0]  DB_LAST     = CNT_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    // Parking value once a non-repeating long press has fired; never equals HOLD_LAST.
    localparam logic [HOLD_W-1:0] HOLD_SAT    = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - REPEAT_CYCLES);

    if (DB_CYCLES < 1 || 64'(DB_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_db
        $error("debouncer_multi: DB_CYCLES out of range for CNT_W");
    end
    if (HOLD_CYCLES < 1 || 64'(HOLD_CYCLES) >= (64'd1 << HOLD_W)) begin : g_bad_hold
        $error("debouncer_multi: HOLD_CYCLES out of range for HOLD_W");
    end
    if (REPEAT_CYCLES < 0 || REPEAT_CYCLES > HOLD_CYCLES) begin : g_bad_repeat
        $error("debouncer_multi: REPEAT_CYCLES must be within 0..HOLD_CYCLES");
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic              p;
        logic              s0_reg;
        logic              s1_reg;
        logic              state_reg;
        logic              state_next;
        logic [CNT_W-1:0]  cnt_reg;
        logic [CNT_W-1:0]  cnt_next;
        logic [HOLD_W-1:0] hcnt_reg;
        logic [HOLD_W-1:0] hcnt_next;
        logic              press_reg;
        logic              press_next;
        logic              release_reg;
        logic              release_next;
        logic              long_reg;
        logic              long_next;

        assign p = (ACTIVE_LOW != 0) ? ~pressed[gi] : pressed[gi];

        always_comb begin
            state_next   = state_reg;
            cnt_next     = cnt_reg;
            hcnt_next    = hcnt_reg;
            press_next   = 1'b0;
            release_next = 1'b0;
            long_next    = 1'b0;

            if (s1_reg == state_reg) begin
                cnt_next = '0;
            end else if (cnt_reg != DB_LAST) begin
                cnt_next = cnt_reg + 1'b1;
            end else begin
                state_next   = s1_reg;
                cnt_next     = '0;
                press_next   = s1_reg;
                release_next = ~s1_reg;
            end

            // Clearing on the falling edge itself keeps long and release pulses exclusive.
            if (!state_reg || release_next) begin
                hcnt_next = '0;
            end else if (hcnt_reg == HOLD_LAST) begin
                long_next = 1'b1;
                hcnt_next = (REPEAT_CYCLES == 0) ? HOLD_SAT : HOLD_RELOAD;
            end else if (hcnt_reg != HOLD_SAT) begin
                hcnt_next = hcnt_reg + 1'b1;
            end
        end

        always_ff @(posedge clk50M or negedge reset_n) begin
            if (!reset_n) begin
                s0_reg      <= 1'b0;
                s1_reg      <= 1'b0;
                state_reg   <= 1'b0;
                cnt_reg     <= '0;
                hcnt_reg    <= '0;
                press_reg   <= 1'b0;
                release_reg <= 1'b0;
                long_reg    <= 1'b0;
            end else begin
                s0_reg      <= p;
                s1_reg      <= s0_reg;
                state_reg   <= state_next;
                cnt_reg     <= cnt_next;
                hcnt_reg    <= hcnt_next;
                press_reg   <= press_next;
                release_reg <= release_next;
                long_reg    <= long_next;
            end
        end

        assign pressed_state[gi] = state_reg;
        assign press_pulse[gi]   = press_reg;
        assign release_pulse[gi] = release_reg;
        assign long_pulse[gi]    = long_reg;
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: stimulus table, hand-written corner sequences and random
// toggling, all checked each cycle against a history-window/elapsed-time reference model.
module tb_debouncer_multi;

    localparam int CH = 4;
    localparam int DB = 4;
    localparam int H  = 10;
    localparam int R  = 3;

    logic          clk50M;
    logic          reset_n;
    logic [CH-1:0] pressed;
    logic [CH-1:0] pressed_state;
    logic [CH-1:0] press_pulse;
    logic [CH-1:0] release_pulse;
    logic [CH-1:0] long_pulse;

    debouncer_multi #(
        .CHANNELS     (CH),
        .CNT_W        (16),
        .DB_CYCLES    (DB),
        .ACTIVE_LOW   (1),
        .HOLD_W       (26),
        .HOLD_CYCLES  (H),
        .REPEAT_CYCLES(R)
    ) dut (
        .clk50M       (clk50M),
        .reset_n      (reset_n),
        .pressed      (pressed),
        .pressed_state(pressed_state),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    initial clk50M = 1'b0;
    always #10 clk50M = ~clk50M;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: level flips once the synchronised input has disagreed with it for
    // DB consecutive cycles; long pulses fall at press + H + k*R while still held.
    logic [CH-1:0] m_state, m_press, m_rel, m_long;
    logic [31:0]   hist [CH];
    int            press_edge [CH];
    int            edge_no;

    typedef struct {
        logic [CH-1:0] raw;
        int            cycles;
        logic [CH-1:0] exp_state;
        logic [CH-1:0] exp_press;
        logic [CH-1:0] exp_rel;
    } vec_t;
    vec_t vecs [8];

    function automatic void check(string name, logic [CH-1:0] act, logic [CH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        m_state = '0;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        edge_no = 0;
        for (int c = 0; c < CH; c++) begin
            hist[c]       = '0;
            press_edge[c] = 0;
        end
    endfunction

    function automatic void model_step();
        if (!reset_n) begin
            model_clear();
            return;
        end
        edge_no++;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        for (int c = 0; c < CH; c++) begin
            logic flip;
            int   d;
            hist[c] = {hist[c][30:0], ~pressed[c]};
            flip = 1'b1;
            for (int j = 2; j <= DB + 1; j++)
                if (hist[c][j] == m_state[c]) flip = 1'b0;
            if (flip) begin
                m_state[c] = ~m_state[c];
                if (m_state[c]) begin
                    m_press[c]    = 1'b1;
                    press_edge[c] = edge_no;
                end else begin
                    m_rel[c] = 1'b1;
                end
            end else if (m_state[c]) begin
                d = edge_no - press_edge[c];
                if (d == H || (R > 0 && d > H && (d - H) % R == 0)) m_long[c] = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk50M);
        model_step();
        #1;
        check("model_state",   pressed_state, m_state);
        check("model_press",   press_pulse,   m_press);
        check("model_release", release_pulse, m_rel);
        check("model_long",    long_pulse,    m_long);
    endtask

    task automatic apply_reset(int n);
        reset_n = 1'b0;
        model_clear();
        #1;
        check("reset_state",   pressed_state, '0);
        check("reset_press",   press_pulse,   '0);
        check("reset_release", release_pulse, '0);
        check("reset_long",    long_pulse,    '0);
        repeat (n) tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_press(int c);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (press_pulse[c]) ok = 1'b1;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL wait_press: ch%0d got no press_pulse required one within 20 cycles", c);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CH-1:0] seen_p, seen_r, seen_l;

        vecs[0] = '{4'hF, 10, 4'h0, 4'h0, 4'h0};
        vecs[1] = '{4'hE,  8, 4'h1, 4'h1, 4'h0};
        vecs[2] = '{4'hC,  3, 4'h1, 4'h0, 4'h0};
        vecs[3] = '{4'hC,  5, 4'h3, 4'h2, 4'h0};
        vecs[4] = '{4'hF,  8, 4'h0, 4'h0, 4'h3};
        vecs[5] = '{4'h5,  8, 4'hA, 4'hA, 4'h0};
        vecs[6] = '{4'hA,  8, 4'h5, 4'h5, 4'hA};
        vecs[7] = '{4'hF,  8, 4'h0, 4'h0, 4'h5};

        pressed = '1;
        reset_n = 1'b1;
        model_clear();
        #3;
        apply_reset(3);

        // Idle with all buttons released
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_outputs", pressed_state | press_pulse | release_pulse | long_pulse, '0);
        end

        for (int v = 0; v < 8; v++) begin
            seen_p  = '0;
            seen_r  = '0;
            pressed = vecs[v].raw;
            for (int k = 0; k < vecs[v].cycles; k++) begin
                tick();
                seen_p |= press_pulse;
                seen_r |= release_pulse;
            end
            check($sformatf("vec%0d_state", v),   pressed_state, vecs[v].exp_state);
            check($sformatf("vec%0d_press", v),   seen_p,        vecs[v].exp_press);
            check($sformatf("vec%0d_release", v), seen_r,        vecs[v].exp_rel);
        end

        // Clean press on ch0: level and pulse at edge DB+2
        pressed[0] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("clean_press_pulse", press_pulse,   (i == 6) ? 4'b0001 : 4'b0000);
            check("clean_press_state", pressed_state, (i >= 6) ? 4'b0001 : 4'b0000);
        end
        pressed = '1;
        repeat (12) tick();

        // Bounce on ch1, toggling every 3 cycles, then settling low
        for (int i = 0; i < 40; i++) begin
            pressed[1] = ((i / 3) % 2 == 1) ? 1'b0 : 1'b1;
            tick();
            check("bounce_state", pressed_state, 4'b0000);
            check("bounce_press", press_pulse,   4'b0000);
        end
        for (int j = 2; j <= 10; j++) begin
            tick();
            check("bounce_settle_press", press_pulse, (j == 6) ? 4'b0010 : 4'b0000);
        end
        // Release lands exactly where the first long pulse would have been
        pressed = '1;
        seen_l  = '0;
        seen_r  = '0;
        for (int j = 0; j < 12; j++) begin
            tick();
            seen_l |= long_pulse;
            seen_r |= release_pulse;
        end
        check("bounce_release_no_long", seen_l, 4'b0000);
        check("bounce_release_seen",    seen_r, 4'b0010);

        // Long press with auto-repeat on ch2
        pressed[2] = 1'b0;
        wait_press(2);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("long_repeat", long_pulse,
                  (k == 10 || k == 13 || k == 16 || k == 19) ? 4'b0100 : 4'b0000);
        end
        pressed[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("long_release_pulse", release_pulse, (k == 6) ? 4'b0100 : 4'b0000);
            check("long_after_release", long_pulse, (k == 2 || k == 5) ? 4'b0100 : 4'b0000);
        end

        // Short press on ch3: level held 7 cycles, no long pulse
        pressed[3] = 1'b0;
        wait_press(3);
        tick();
        pressed[3] = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            tick();
            check("short_release", release_pulse, (j == 6) ? 4'b1000 : 4'b0000);
            check("short_no_long", long_pulse,    4'b0000);
        end

        // Reset with ch0 held and ch3 mid-debounce
        pressed[0] = 1'b0;
        wait_press(0);
        pressed[3] = 1'b0;
        repeat (4) tick();
        apply_reset(3);
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("post_reset_press",   press_pulse,   (j == 6) ? 4'b1001 : 4'b0000);
            check("post_reset_release", release_pulse, 4'b0000);
        end
        pressed = '1;
        repeat (12) tick();

        // Random toggling with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 9) == 0) pressed[c] = ~pressed[c];
            if ($urandom_range(0, 999) == 0) apply_reset(2);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
